// File: rtl/lfsr_sample_buffer_pkg.sv
// Shared types and constants for the lfsr sample buffer.
// Provides package lfsr_pkg. The optional period monitor (macro PERIOD_MON_EN)
// uses the state type below.
package lfsr_pkg;

    localparam int LFSR_W = 16;

    typedef enum logic [1:0] {
        MON_IDLE,
        MON_ARMED,
        MON_COUNT,
        MON_DONE
    } mon_state_t;

endpackage

// File: rtl/lfsr_sample_buffer_if.sv
// Valid/ready stream carrying random words from the sample buffer to a client.
// The master drives data/valid, the slave drives ready.
interface lfsr_sample_buffer_if #(
    parameter int WIDTH = 16
) ();

    logic [WIDTH-1:0] rnd_data;
    logic             rnd_valid;
    logic             rnd_ready;

    modport master (
        output rnd_data,
        output rnd_valid,
        input  rnd_ready
    );

    modport slave (
        input  rnd_data,
        input  rnd_valid,
        output rnd_ready
    );

endinterface

// File: rtl/lfsr_sample_buffer_sync_fifo.sv
// Synchronous show-ahead FIFO. The head word and its valid flag are registered,
// so a word pushed into an empty FIFO is visible right after the push edge.
// A push into a full FIFO is accepted only if a pop happens in the same cycle.
module sync_fifo #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_valid,
    output logic [CW-1:0]    o_count,
    output logic             o_full
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_head;
    logic             r_valid;

    logic             w_pop;
    logic             w_push;
    logic [AW-1:0]    w_rd_next;
    logic [CW-1:0]    w_left;
    logic [CW-1:0]    w_count_next;
    logic [WIDTH-1:0] w_head_next;

    assign o_full       = (r_count == CW'(DEPTH));
    assign w_pop        = i_pop && r_valid;
    assign w_push       = i_push && (!o_full || w_pop);
    assign w_rd_next    = r_rd_ptr + AW'(w_pop);
    assign w_left       = r_count - CW'(w_pop);
    assign w_count_next = w_left + CW'(w_push);

    // Select the word that becomes the head after this edge.
    always_comb begin
        // NOTE: default first so every path assigns the signal and no latch is inferred.
        w_head_next = r_head;
        if (w_count_next != '0) begin
            if (w_left == '0) begin
                w_head_next = i_data;          // FIFO was (or became) empty: bypass
            end else begin
                w_head_next = r_mem[w_rd_next];
            end
        end
    end

    // Storage write.
    // NOTE: the memory array is deliberately not reset; the pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers, occupancy and registered head.
    // NOTE: non-blocking assignments so all registers update from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_wr_ptr <= r_wr_ptr + AW'(w_push);
            r_rd_ptr <= w_rd_next;
            r_count  <= w_count_next;
            r_head   <= w_head_next;
            r_valid  <= (w_count_next != '0);
        end
    end

    assign o_head  = r_head;
    assign o_valid = r_valid;
    assign o_count = r_count;

endmodule

// File: rtl/lfsr_sample_buffer.sv
// lfsr_sample_buffer: samples the 16-bit lfsr state on every enabled cycle,
// buffers the samples in a show-ahead FIFO and serves them on a valid/ready
// stream. A sticky overflow flag records dropped samples.
// Optional feature macro: PERIOD_MON_EN adds a monitor that measures the lfsr
// period (samples until the first sampled state reappears).
module lfsr_sample_buffer
    import lfsr_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 8,
    parameter int PERIOD_W = 17
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [LFSR_W-1:0]      lfsr_q,
    input  logic                   lfsr_en,
    lfsr_sample_buffer_if.master   rnd,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   overflow,
    output logic                   period_done,
    output logic [PERIOD_W-1:0]    period_len
);

    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_valid;
    logic [WIDTH-1:0] w_head;
    logic             r_overflow;

    assign w_push = lfsr_en && !reset;
    assign w_pop  = w_valid && rnd.rnd_ready;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (lfsr_q[WIDTH-1:0]),
        .i_pop   (rnd.rnd_ready),
        .o_head  (w_head),
        .o_valid (w_valid),
        .o_count (fifo_count),
        .o_full  (w_full)
    );

    assign rnd.rnd_data  = w_head;
    assign rnd.rnd_valid = w_valid;

    // Sticky flag: a sample arrived while full with no pop to make room.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_push && w_full && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

    assign overflow = r_overflow;

`ifdef PERIOD_MON_EN
    mon_state_t          r_state;
    mon_state_t          w_state_next;
    logic [LFSR_W-1:0]   r_ref;
    logic [LFSR_W-1:0]   w_ref_next;
    logic [PERIOD_W-1:0] r_cnt;
    logic [PERIOD_W-1:0] w_cnt_next;
    logic [PERIOD_W-1:0] r_len;
    logic [PERIOD_W-1:0] w_len_next;

    // Monitor registers; the FSM only moves on enabled lfsr cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= MON_IDLE;
            r_ref   <= '0;
            r_cnt   <= '0;
            r_len   <= '0;
        end else begin
            r_state <= w_state_next;
            r_ref   <= w_ref_next;
            r_cnt   <= w_cnt_next;
            r_len   <= w_len_next;
        end
    end

    // Next-state logic. r_cnt is the number of samples seen since the reference,
    // so the matching sample itself makes the period r_cnt + 1.
    always_comb begin
        w_state_next = r_state;
        w_ref_next   = r_ref;
        w_cnt_next   = r_cnt;
        w_len_next   = r_len;
        if (lfsr_en) begin
            unique case (r_state)
                MON_IDLE: begin
                    w_state_next = MON_ARMED;
                    w_ref_next   = lfsr_q;
                    w_cnt_next   = '0;
                end
                MON_ARMED: begin
                    w_state_next = MON_COUNT;
                    w_cnt_next   = PERIOD_W'(1);
                end
                MON_COUNT: begin
                    if (lfsr_q == r_ref) begin
                        w_state_next = MON_DONE;
                        w_len_next   = (&r_cnt) ? r_cnt : r_cnt + PERIOD_W'(1);
                    end else if (&r_cnt) begin
                        w_state_next = MON_DONE;
                        w_len_next   = '1;
                    end else begin
                        w_cnt_next   = r_cnt + PERIOD_W'(1);
                    end
                end
                MON_DONE: begin
                    w_state_next = MON_DONE;
                end
                default: begin
                    w_state_next = MON_IDLE;
                end
            endcase
        end
    end

    assign period_done = (r_state == MON_DONE);
    assign period_len  = r_len;
`else
    assign period_done = 1'b0;
    assign period_len  = '0;
`endif

endmodule

// File: tb/tb_lfsr_sample_buffer.sv
// Directed testbench for lfsr_sample_buffer. The bench plays the lfsr itself
// (maximal 16-bit Galois lfsr, mask 16'hB400) and checks stream order,
// backpressure, overflow, drain and reset behaviour. Period checks run only
// when PERIOD_MON_EN is defined.
module tb_lfsr_sample_buffer;

    localparam int WIDTH    = 16;
    localparam int DEPTH    = 8;
    localparam int PERIOD_W = 17;

    logic                   clk;
    logic                   reset;
    logic [15:0]            lfsr_q;
    logic                   lfsr_en;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   overflow;
    logic                   period_done;
    logic [PERIOD_W-1:0]    period_len;

    int checks;
    int errors;

    lfsr_sample_buffer_if #(.WIDTH(WIDTH)) rnd_if ();

    lfsr_sample_buffer #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .PERIOD_W (PERIOD_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .lfsr_q      (lfsr_q),
        .lfsr_en     (lfsr_en),
        .rnd         (rnd_if),
        .fifo_count  (fifo_count),
        .overflow    (overflow),
        .period_done (period_done),
        .period_len  (period_len)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    // One clock; the bench lfsr advances on enabled edges like the real stage.
    task automatic tick();
        @(posedge clk);
        #1;
        if (lfsr_en) lfsr_q = lfsr_next(lfsr_q);
    endtask

    task automatic do_reset();
        reset = 1'b1; lfsr_en = 1'b0; rnd_if.rnd_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; lfsr_en = 1'b1; rnd_if.rnd_ready = 1'b1; lfsr_q = 16'h1234;
        tick(); tick();
        checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", fifo_count); end
        checks++; if (rnd_if.rnd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", rnd_if.rnd_valid); end
        checks++; if (rnd_if.rnd_data !== 16'h0) begin errors++; $display("FAIL reset_data got %h want 0000", rnd_if.rnd_data); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
        checks++; if (period_done !== 1'b0) begin errors++; $display("FAIL reset_period_done got %b want 0", period_done); end
        checks++; if (period_len !== '0) begin errors++; $display("FAIL reset_period_len got %0d want 0", period_len); end
        reset = 1'b0; lfsr_en = 1'b0;
    endtask

    task automatic test_stream();
        logic [15:0] prev;
        do_reset();
        lfsr_q = 16'habcd; lfsr_en = 1'b1; rnd_if.rnd_ready = 1'b1;
        tick();
        checks++; if (rnd_if.rnd_valid !== 1'b1) begin errors++; $display("FAIL stream_first_valid got %b want 1", rnd_if.rnd_valid); end
        checks++; if (rnd_if.rnd_data !== 16'habcd) begin errors++; $display("FAIL stream_first_data got %h want abcd", rnd_if.rnd_data); end
        checks++; if (fifo_count !== 4'd1) begin errors++; $display("FAIL stream_first_count got %0d want 1", fifo_count); end
        for (int i = 0; i < 6; i++) begin
            prev = lfsr_q;
            tick();
            checks++; if (rnd_if.rnd_data !== prev) begin errors++; $display("FAIL stream_data[%0d] got %h want %h", i, rnd_if.rnd_data, prev); end
            checks++; if (fifo_count !== 4'd1) begin errors++; $display("FAIL stream_count[%0d] got %0d want 1", i, fifo_count); end
        end
        lfsr_en = 1'b0;
    endtask

    task automatic test_overflow();
        logic [15:0] w [8];
        logic [3:0]  exp_cnt;
        do_reset();
        lfsr_q = 16'habcd; lfsr_en = 1'b1; rnd_if.rnd_ready = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            if (k <= 8) w[k-1] = lfsr_q;
            tick();
            exp_cnt = (k < 8) ? 4'(k) : 4'd8;
            checks++; if (fifo_count !== exp_cnt) begin errors++; $display("FAIL ovf_count[%0d] got %0d want %0d", k, fifo_count, exp_cnt); end
            checks++; if (overflow !== (k >= 9)) begin errors++; $display("FAIL ovf_flag[%0d] got %b want %b", k, overflow, (k >= 9)); end
            checks++; if (rnd_if.rnd_data !== 16'habcd) begin errors++; $display("FAIL ovf_head[%0d] got %h want abcd", k, rnd_if.rnd_data); end
        end
        lfsr_en = 1'b0; rnd_if.rnd_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++; if (rnd_if.rnd_valid !== 1'b1 || rnd_if.rnd_data !== w[i]) begin
                errors++; $display("FAIL ovf_drain[%0d] got %b/%h want 1/%h", i, rnd_if.rnd_valid, rnd_if.rnd_data, w[i]);
            end
            tick();
        end
        checks++; if (rnd_if.rnd_valid !== 1'b0 || fifo_count !== 4'd0) begin errors++; $display("FAIL ovf_empty got %b/%0d want 0/0", rnd_if.rnd_valid, fifo_count); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", overflow); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] q [$];
        do_reset();
        lfsr_q = 16'h0001; lfsr_en = 1'b1; rnd_if.rnd_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            q.push_back(lfsr_q);
            tick();
        end
        checks++; if (fifo_count !== 4'd8 || overflow !== 1'b0) begin errors++; $display("FAIL b2b_full got %0d/%b want 8/0", fifo_count, overflow); end
        rnd_if.rnd_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++; if (rnd_if.rnd_data !== q[0]) begin errors++; $display("FAIL b2b_head[%0d] got %h want %h", k, rnd_if.rnd_data, q[0]); end
            void'(q.pop_front());
            q.push_back(lfsr_q);
            tick();
            checks++; if (fifo_count !== 4'd8 || overflow !== 1'b0) begin errors++; $display("FAIL b2b_count[%0d] got %0d/%b want 8/0", k, fifo_count, overflow); end
        end
        lfsr_en = 1'b0;
        for (int k = 0; k < 8; k++) begin
            checks++; if (rnd_if.rnd_data !== q[k]) begin errors++; $display("FAIL b2b_drain[%0d] got %h want %h", k, rnd_if.rnd_data, q[k]); end
            tick();
        end
        checks++; if (rnd_if.rnd_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got %b want 0", rnd_if.rnd_valid); end
    endtask

    task automatic test_idle_drain();
        logic [15:0] w [3];
        do_reset();
        lfsr_q = 16'h8000; lfsr_en = 1'b1; rnd_if.rnd_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            w[k] = lfsr_q;
            tick();
        end
        checks++; if (fifo_count !== 4'd3) begin errors++; $display("FAIL idle_fill got %0d want 3", fifo_count); end
        lfsr_en = 1'b0; rnd_if.rnd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (rnd_if.rnd_data !== w[i] || fifo_count !== 4'(3 - i)) begin
                errors++; $display("FAIL idle_drain[%0d] got %h/%0d want %h/%0d", i, rnd_if.rnd_data, fifo_count, w[i], 3 - i);
            end
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            checks++; if (rnd_if.rnd_valid !== 1'b0 || fifo_count !== 4'd0) begin
                errors++; $display("FAIL idle_empty[%0d] got %b/%0d want 0/0", i, rnd_if.rnd_valid, fifo_count);
            end
            tick();
        end
    endtask

`ifdef PERIOD_MON_EN
    task automatic test_period();
        int n;
        do_reset();
        lfsr_q = 16'habcd; lfsr_en = 1'b1; rnd_if.rnd_ready = 1'b1;
        n = 0;
        while (n < 70000 && period_done !== 1'b1) begin
            tick();
            n++;
        end
        checks++; if (period_done !== 1'b1 || n != 65536) begin errors++; $display("FAIL period_done_tick got %b/%0d want 1/65536", period_done, n); end
        checks++; if (period_len !== PERIOD_W'(65535)) begin errors++; $display("FAIL period_len got %0d want 65535", period_len); end
        checks++; if (fifo_count !== 4'd1) begin errors++; $display("FAIL period_fifo got %0d want 1", fifo_count); end
        tick(); tick();
        checks++; if (period_done !== 1'b1 || period_len !== PERIOD_W'(65535)) begin errors++; $display("FAIL period_hold got %b/%0d want 1/65535", period_done, period_len); end
        reset = 1'b1;
        tick();
        reset = 1'b0; lfsr_en = 1'b0;
        checks++; if (period_done !== 1'b0 || period_len !== '0) begin errors++; $display("FAIL period_reset got %b/%0d want 0/0", period_done, period_len); end
    endtask
`endif

    task automatic test_reset_mid();
        do_reset();
        lfsr_q = 16'h5a5a; lfsr_en = 1'b1; rnd_if.rnd_ready = 1'b0;
        for (int k = 0; k < 9; k++) tick();
        lfsr_en = 1'b0; rnd_if.rnd_ready = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        checks++; if (fifo_count !== 4'd5 || overflow !== 1'b1) begin errors++; $display("FAIL mid_pre got %0d/%b want 5/1", fifo_count, overflow); end
        reset = 1'b1; lfsr_en = 1'b1;
        tick();
        checks++; if (fifo_count !== 4'd0 || rnd_if.rnd_valid !== 1'b0) begin errors++; $display("FAIL mid_reset got %0d/%b want 0/0", fifo_count, rnd_if.rnd_valid); end
        checks++; if (overflow !== 1'b0 || rnd_if.rnd_data !== 16'h0) begin errors++; $display("FAIL mid_reset_flags got %b/%h want 0/0000", overflow, rnd_if.rnd_data); end
        checks++; if (period_done !== 1'b0) begin errors++; $display("FAIL mid_reset_mon got %b want 0", period_done); end
        reset = 1'b0; lfsr_en = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        lfsr_en = 1'b0;
        lfsr_q = 16'h0;
        rnd_if.rnd_ready = 1'b0;
        test_reset();
        test_stream();
        test_overflow();
        test_back_to_back();
        test_idle_drain();
`ifdef PERIOD_MON_EN
        test_period();
`endif
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
